// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. Operands are captured on a
// start request and added one bit per cycle (LSB first). The result appears
// on registered outputs together with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_EN adds a 'sub' input selecting A-B
// (two's complement: B inverted on load, carry seeded with 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] resultSr_q;
    logic [CNT_W-1:0] bitCnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;

    logic             halfSum;
    logic             sumBit_d;
    logic             carry_d;
    logic [WIDTH-1:0] resultNext_d;
    logic [WIDTH-1:0] bLoad_d;
    logic             carryInit_d;

    // One full-adder slice built from two half-adders and an OR, plus the
    // result register with the new bit entering at the MSB.
    always_comb begin
        halfSum      = opA_q[0] ^ opB_q[0];
        sumBit_d     = halfSum ^ carry_q;
        carry_d      = (opA_q[0] & opB_q[0]) | (carry_q & halfSum);
        resultNext_d = {sumBit_d, {(WIDTH-1){1'b0}}} | (resultSr_q >> 1);
    end

    // Operand B and carry seed as loaded at acceptance (inverted/1 for subtract).
`ifdef SERIAL_SUB_EN
    always_comb begin
        bLoad_d     = sub ? ~b_in : b_in;
        carryInit_d = sub;
    end
`else
    always_comb begin
        bLoad_d     = b_in;
        carryInit_d = 1'b0;
    end
`endif

    // Controller FSM and datapath registers; sum/co change only on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            resultSr_q <= '0;
            bitCnt_q   <= '0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            co_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opA_q      <= a_in;
                        opB_q      <= bLoad_d;
                        carry_q    <= carryInit_d;
                        resultSr_q <= '0;
                        bitCnt_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    opA_q      <= opA_q >> 1;
                    opB_q      <= opB_q >> 1;
                    resultSr_q <= resultNext_d;
                    carry_q    <= carry_d;
                    bitCnt_q   <= bitCnt_q + CNT_W'(1);
                    if (bitCnt_q == LAST_BIT) begin
                        sum_q   <= resultNext_d;
                        co_q    <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Subtraction vectors are included when SERIAL_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
`ifdef SERIAL_SUB_EN
    logic             subIn;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    int checkCount;
    int passCount;

    logic [WIDTH-1:0] heldSum;
    logic             heldCo;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (aIn),
        .b_in  (bIn),
`ifdef SERIAL_SUB_EN
        .sub   (subIn),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns in cycle 1 of the run.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        aIn   = a;
        bIn   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        aIn   = 8'hA5;
        bIn   = 8'hC3;
    endtask

    // Called in cycle 1: checks busy for cycles 1..8, done in cycle 9 with the
    // expected result, then done dropping and the result holding.
    task automatic runToDone(input string tag, input logic [WIDTH-1:0] expSum,
                             input logic expCo);
        checkOutput({tag, ".busyC1"}, 32'(busy), 32'd1);
        checkOutput({tag, ".doneC1"}, 32'(done), 32'd0);
        for (int k = 2; k <= WIDTH; k++) begin
            tick();
            checkOutput({tag, ".busyRun"}, 32'(busy), 32'd1);
            checkOutput({tag, ".doneRun"}, 32'(done), 32'd0);
            checkOutput({tag, ".sumHeldRun"}, 32'(sum), 32'(heldSum));
            checkOutput({tag, ".coHeldRun"}, 32'(co), 32'(heldCo));
        end
        tick();
        checkOutput({tag, ".busyDone"}, 32'(busy), 32'd0);
        checkOutput({tag, ".doneDone"}, 32'(done), 32'd1);
        checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
        checkOutput({tag, ".co"}, 32'(co), 32'(expCo));
        heldSum = expSum;
        heldCo  = expCo;
        tick();
        checkOutput({tag, ".doneDrop"}, 32'(done), 32'd0);
        checkOutput({tag, ".busyIdle"}, 32'(busy), 32'd0);
        checkOutput({tag, ".sumHold"}, 32'(sum), 32'(expSum));
        checkOutput({tag, ".coHold"}, 32'(co), 32'(expCo));
    endtask

    // Directed test sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        heldSum    = '0;
        heldCo     = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        aIn        = '0;
        bIn        = '0;
`ifdef SERIAL_SUB_EN
        subIn      = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.sum", 32'(sum), 32'd0);
        checkOutput("rst.co", 32'(co), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle.busy", 32'(busy), 32'd0);

        // Plain addition: 0x5A + 0x33 = 0x8D, no carry
        applyStimulus(8'h5A, 8'h33);
        runToDone("add", 8'h8D, 1'b0);

        // Reset during RUN cycle 5 aborts with cleared outputs and no done
        applyStimulus(8'h5A, 8'h33);
        for (int k = 2; k <= 5; k++) tick();
        checkOutput("abort.busyC5", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.sum", 32'(sum), 32'd0);
        checkOutput("abort.co", 32'(co), 32'd0);
        heldSum = '0;
        heldCo  = 1'b0;
        for (int k = 0; k < WIDTH + 2; k++) begin
            tick();
            checkOutput("abort.noDone", 32'(done), 32'd0);
            checkOutput("abort.idleBusy", 32'(busy), 32'd0);
        end

        // Overflow: 0xFF + 0x01 = 0x00 with carry out, result holds afterwards
        applyStimulus(8'hFF, 8'h01);
        runToDone("ovf", 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("ovf.sumIdle", 32'(sum), 32'd0);
            checkOutput("ovf.coIdle", 32'(co), 32'd1);
        end

        // Start ignored in RUN (cycle 3) and DONE (cycle 9), accepted in cycle 10
        applyStimulus(8'h12, 8'h34);
        tick();
        tick();
        aIn   = 8'hF0;
        bIn   = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 4; k <= WIDTH; k++) tick();
        checkOutput("ign.done", 32'(done), 32'd1);
        checkOutput("ign.sum", 32'(sum), 32'h46);
        checkOutput("ign.co", 32'(co), 32'd0);
        heldSum = 8'h46;
        heldCo  = 1'b0;
        aIn   = 8'hF0;
        bIn   = 8'hF0;
        start = 1'b1;
        tick();
        checkOutput("ign.busyAfterDone", 32'(busy), 32'd0);
        checkOutput("ign.doneAfterDone", 32'(done), 32'd0);
        applyStimulus(8'h80, 8'h80);
        runToDone("acc", 8'h00, 1'b1);

`ifdef SERIAL_SUB_EN
        // Subtraction: 0x10 - 0x01 = 0x0F (no borrow), 0x01 - 0x02 = 0xFF (borrow)
        subIn = 1'b1;
        applyStimulus(8'h10, 8'h01);
        subIn = 1'b0;
        runToDone("sub1", 8'h0F, 1'b1);
        subIn = 1'b1;
        applyStimulus(8'h01, 8'h02);
        subIn = 1'b0;
        runToDone("sub2", 8'hFF, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
